imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Boot-time writer for the instruction memory. It accepts a byte stream from the host link (UART/JTAG bridge) over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word goes through the instruction memory's write port at consecutive word addresses 0, 1, 2, …. The pipeline CPU is held in stall until the whole program is written.

Parameters:
DEPTH, 400, number of 32-bit words in instruction memory; legal program length is 1..DEPTH
ADDR_W, 32, width of word address and length fields (matches pc width)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  single-cycle request to begin a load; sampled only in IDLE, DONE, ERR
prog_len  in  ADDR_W  program length in words, latched when start is accepted
byte_valid  in  1  host byte available
byte_data  in  8  host byte
byte_ready  out  1  loader accepts byte this cycle
wr_en  out  1  instruction memory write strobe, one cycle per word
wr_addr  out  ADDR_W  word address of write (same indexing as pc)
wr_data  out  32  assembled instruction word
busy  out  1  high in RECV and WRITE
done  out  1  program fully written
error  out  1  rejected length
cpu_hold  out  1  stall request to pipeline; high until a load completes

Behaviour:
- Reset (reset==0 at a rising edge) gives: state IDLE; byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, cpu_hold=1. Byte counter, word counter and partial word are cleared. Reset mid-load discards any partial word. Words already written stay in memory.
- All outputs are registered, except byte_ready, which is decoded from state (RECV only).
- States: IDLE, RECV, WRITE, DONE, ERR.
- IDLE/DONE/ERR, start==1:
  - prog_len in 1..DEPTH -> RECV. Latch len, word_addr=0, byte_cnt=0. Clear done and error. Set cpu_hold=1.
  - prog_len==0 or >DEPTH -> ERR. Set error=1, done=0, cpu_hold=1.
- start is ignored in RECV and WRITE.
- RECV: byte_ready=1. A byte is accepted on a cycle with byte_valid & byte_ready.
  - byte_cnt k (0..3) places byte_data into word bits [8k+7:8k]. The first byte is the LSB.
  - byte_cnt increments mod 4.
  - Accepting the 4th byte moves to WRITE on the next edge.
  - byte_valid=0 stalls indefinitely with no timeout. Bytes arriving outside RECV are not consumed.
- WRITE: byte_ready=0. For exactly one cycle, wr_en=1, wr_addr=word_addr, wr_data=the assembled word.
  - Then word_addr increments.
  - If word_addr+1==len -> DONE, otherwise -> RECV.
  - wr_en is asserted in the cycle after the 4th byte handshake.
  - Peak throughput is 1 word per 5 cycles.
- DONE: done=1 and cpu_hold=0, held until reset or an accepted start. wr_addr holds the last written address.
- ERR: error=1 and cpu_hold=1, held until reset or a valid start.
- busy=1 exactly in RECV and WRITE.
- wr_addr never exceeds DEPTH-1. The word counter does not wrap, because len≤DEPTH is enforced at start.
- Memory write port contract: synchronous write on the clk edge where wr_en=1. The read side (pc -> instruction) is combinational and unaffected by this block.

Test Plan:
- Reset, then start with prog_len=2 and bytes 13,00,50,00,B3,82,62,40 with byte_valid held high -> wr_en pulses twice. First pulse: addr 0, data 0x00500013. Second pulse: addr 1, data 0x406282B3. done=1 and cpu_hold=0 on the cycle after the second WRITE. Total 10 cycles from the first accepted byte.
- byte_valid toggled 1,0,0,1,… randomly during a 3-word load -> identical words and addresses. No byte is lost or duplicated. byte_ready is never high in WRITE.
- start with prog_len=0, then separately prog_len=401 -> ERR with error=1, cpu_hold=1, no wr_en. A following start with prog_len=1 and bytes EF,BE,AD,DE -> addr 0, data 0xDEADBEEF, error cleared, done=1.
- prog_len=400 with 1600 bytes -> last write at addr 399. done=1. No write at addr ≥400.
- Reset asserted after 6 bytes of a 4-word load -> all outputs at reset values the next cycle. A subsequent load writes from addr 0 with no stale partial bytes.
- start pulsed during RECV and during WRITE -> ignored. len and address sequence unchanged. After DONE, a second start reloads from addr 0 with done dropping to 0.

Source files
------------

// File: rtl/imem_loader_if.sv
// ============================================================================
// Module   : imem_loader_if
// Brief    : Host byte link and instruction-memory write port of the loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_loader_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] prog_len;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_hold;

  modport master (
    output start, prog_len, byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data, busy, done, error, cpu_hold
  );

  modport slave (
    input  start, prog_len, byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data, busy, done, error, cpu_hold
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Brief    : Assembles a little-endian byte stream into 32-bit words and writes
//            them to instruction memory from address 0, holding the CPU meanwhile.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int DEPTH  = 400,
  parameter int ADDR_W = 32
) (
  input  wire logic     clk,
  input  wire logic     reset,
  imem_loader_if.slave  bus
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_RECV  = 3'd1;
  localparam logic [2:0] c_WRITE = 3'd2;
  localparam logic [2:0] c_DONE  = 3'd3;
  localparam logic [2:0] c_ERR   = 3'd4;

  localparam logic [ADDR_W-1:0] c_DEPTH = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] c_ONE   = ADDR_W'(1);

  logic [2:0]        state_q,     state_d;
  logic [ADDR_W-1:0] len_q,       len_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic [1:0]        byte_cnt_q,  byte_cnt_d;
  logic [31:0]       word_q,      word_d;

  logic              wr_en_q,    wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
  logic [31:0]       wr_data_q,  wr_data_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              error_q,    error_d;
  logic              cpu_hold_q, cpu_hold_d;

  logic w_len_ok;
  assign w_len_ok = (bus.prog_len != '0) && (bus.prog_len <= c_DEPTH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= c_IDLE;
      len_q       <= '0;
      word_addr_q <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_hold_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_addr_q <= word_addr_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_hold_q  <= cpu_hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_addr_d = word_addr_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    case (state_q)
      c_IDLE, c_DONE, c_ERR: begin
        if (bus.start) begin
          if (w_len_ok) begin
            state_d     = c_RECV;
            len_d       = bus.prog_len;
            word_addr_d = '0;
            byte_cnt_d  = '0;
            word_d      = '0;
          end else begin
            state_d = c_ERR;
          end
        end
      end
      c_RECV: begin
        if (bus.byte_valid) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = c_WRITE;
          end
        end
      end
      c_WRITE: begin
        word_addr_d = word_addr_q + c_ONE;
        state_d     = ((word_addr_q + c_ONE) == len_q) ? c_DONE : c_RECV;
      end
      default: state_d = c_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    wr_en_d    = (state_q == c_RECV) && (state_d == c_WRITE);
    wr_addr_d  = wr_en_d ? word_addr_q : wr_addr_q;
    wr_data_d  = wr_en_d ? word_d : wr_data_q;
    busy_d     = (state_d == c_RECV) || (state_d == c_WRITE);
    done_d     = (state_d == c_DONE);
    error_d    = (state_d == c_ERR);
    cpu_hold_d = (state_d != c_DONE);
  end

  assign bus.byte_ready = (state_q == c_RECV);
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.cpu_hold   = cpu_hold_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed self-checking bench for imem_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;
  localparam int DEPTH  = 400;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic reset;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write-port observer: logs every memory write with its cycle.
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  logic        prev_done = 1'b0;
  int          done_rise = -1;
  int          overlap   = 0;
  int          bad_addr  = 0;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      log_addr.push_back(bus.wr_addr);
      log_data.push_back(bus.wr_data);
      log_cyc.push_back(cyc);
      if (bus.wr_addr >= DEPTH) bad_addr++;
    end
    if (bus.wr_en && bus.byte_ready) overlap++;
    if (bus.done && !prev_done) done_rise = cyc;
    prev_done = bus.done;
  end

  logic [7:0] tx_q[$];

  task automatic push_word(input logic [31:0] w);
    tx_q.push_back(w[7:0]);
    tx_q.push_back(w[15:8]);
    tx_q.push_back(w[23:16]);
    tx_q.push_back(w[31:24]);
  endtask

  task automatic push_bytes(input bit gaps, input int budget, output int first_edge);
    int n;
    bit hs;
    n = 0;
    first_edge = -1;
    while (tx_q.size() > 0 && n < budget) begin
      @(negedge clk);
      bus.byte_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.byte_data  = tx_q[0];
      hs = bus.byte_valid && bus.byte_ready;
      if (hs && first_edge < 0) first_edge = cyc + 1;
      @(posedge clk);
      if (hs) void'(tx_q.pop_front());
      n++;
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    check("bytes_left", tx_q.size(), 0);
    tx_q.delete();
  endtask

  task automatic do_start(input logic [31:0] len);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.prog_len = len;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !bus.done && !bus.error; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte_ready"}, bus.byte_ready, 0);
    check({tag, "_wr_en"},      bus.wr_en,      0);
    check({tag, "_wr_addr"},    bus.wr_addr,    0);
    check({tag, "_wr_data"},    bus.wr_data,    0);
    check({tag, "_busy"},       bus.busy,       0);
    check({tag, "_done"},       bus.done,       0);
    check({tag, "_error"},      bus.error,      0);
    check({tag, "_cpu_hold"},   bus.cpu_hold,   1);
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'(i) * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  int fe;
  int base;
  logic [31:0] w3[3];

  initial begin
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.prog_len   = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;

    // Back-to-back two-word load with exact timing.
    base = log_addr.size();
    do_start(2);
    check("t1_busy", bus.busy, 1);
    check("t1_hold", bus.cpu_hold, 1);
    push_word(32'h0050_0013);
    push_word(32'h4062_82B3);
    push_bytes(1'b0, 50, fe);
    wait_done(50);
    check("t1_nwr", log_addr.size() - base, 2);
    check("t1_a0", log_addr[base], 0);
    check("t1_d0", log_data[base], 32'h0050_0013);
    check("t1_a1", log_addr[base+1], 1);
    check("t1_d1", log_data[base+1], 32'h4062_82B3);
    check("t1_wcyc0", log_cyc[base] - fe, 3);
    check("t1_wcyc1", log_cyc[base+1] - fe, 8);
    check("t1_donecyc", done_rise - fe, 9);
    check("t1_done", bus.done, 1);
    check("t1_hold_off", bus.cpu_hold, 0);
    check("t1_busy_off", bus.busy, 0);
    check("t1_addr_hold", bus.wr_addr, 1);

    // Three words with random byte_valid gaps.
    w3[0] = 32'h1234_5678; w3[1] = 32'hCAFE_F00D; w3[2] = 32'h0BAD_C0DE;
    base = log_addr.size();
    do_start(3);
    for (int i = 0; i < 3; i++) push_word(w3[i]);
    push_bytes(1'b1, 400, fe);
    wait_done(50);
    check("t2_nwr", log_addr.size() - base, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_a%0d", i), log_addr[base+i], i);
      check($sformatf("t2_d%0d", i), log_data[base+i], w3[i]);
    end
    check("t2_done", bus.done, 1);

    // Rejected lengths, then a valid single-word load.
    base = log_addr.size();
    do_start(0);
    check("t3_err0", bus.error, 1);
    check("t3_done0", bus.done, 0);
    check("t3_hold0", bus.cpu_hold, 1);
    check("t3_busy0", bus.busy, 0);
    do_start(DEPTH + 1);
    check("t3_err401", bus.error, 1);
    check("t3_busy401", bus.busy, 0);
    repeat (3) @(negedge clk);
    check("t3_nowr", log_addr.size() - base, 0);
    do_start(1);
    check("t3_err_clr", bus.error, 0);
    push_word(32'hDEAD_BEEF);
    push_bytes(1'b0, 50, fe);
    wait_done(50);
    check("t3_nwr", log_addr.size() - base, 1);
    check("t3_a", log_addr[base], 0);
    check("t3_d", log_data[base], 32'hDEAD_BEEF);
    check("t3_done", bus.done, 1);
    check("t3_error", bus.error, 0);

    // Full-depth load.
    base = log_addr.size();
    do_start(DEPTH);
    for (int i = 0; i < DEPTH; i++) push_word(pat(i));
    push_bytes(1'b0, 4000, fe);
    wait_done(50);
    check("t4_nwr", log_addr.size() - base, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (log_addr[base+i] !== 32'(i) || log_data[base+i] !== pat(i)) begin
        check($sformatf("t4_a%0d", i), log_addr[base+i], i);
        check($sformatf("t4_d%0d", i), log_data[base+i], pat(i));
      end
    end
    check("t4_last", log_addr[base+DEPTH-1], DEPTH - 1);
    check("t4_done", bus.done, 1);

    // Reset after six bytes of a four-word load.
    do_start(4);
    push_word(32'hA1A2_A3A4);
    tx_q.push_back(8'hB1);
    tx_q.push_back(8'hB2);
    push_bytes(1'b0, 50, fe);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("t5");
    reset = 1'b1;
    base = log_addr.size();
    do_start(1);
    push_word(32'h4433_2211);
    push_bytes(1'b0, 50, fe);
    wait_done(50);
    check("t5_nwr", log_addr.size() - base, 1);
    check("t5_a", log_addr[base], 0);
    check("t5_d", log_data[base], 32'h4433_2211);

    // start pulses during RECV and WRITE must be ignored.
    base = log_addr.size();
    do_start(3);
    for (int i = 0; i < 3; i++) push_word(pat(i + 50));
    fork
      push_bytes(1'b0, 100, fe);
      begin
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.prog_len = 1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 50 && !bus.wr_en; i++) @(negedge clk);
        bus.start = 1'b1; bus.prog_len = 0;
        @(negedge clk);
        bus.start = 1'b0;
      end
    join
    wait_done(50);
    check("t6_nwr", log_addr.size() - base, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t6_a%0d", i), log_addr[base+i], i);
      check($sformatf("t6_d%0d", i), log_data[base+i], pat(i + 50));
    end
    check("t6_done", bus.done, 1);
    check("t6_error", bus.error, 0);

    base = log_addr.size();
    do_start(1);
    check("t6_done_drop", bus.done, 0);
    check("t6_busy", bus.busy, 1);
    push_word(32'h0000_0073);
    push_bytes(1'b0, 50, fe);
    wait_done(50);
    check("t6_re_a", log_addr[base], 0);
    check("t6_re_d", log_data[base], 32'h0000_0073);
    check("t6_re_done", bus.done, 1);

    check("ready_in_write", overlap, 0);
    check("addr_overflow", bad_addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
